// File: rtl/regbank_pkg.sv
// Shared definitions for the multi-port register bank: write-back modes and
// the hardwired zero register index.
package regbank_pkg;

  typedef enum logic [1:0] {
    WR_FULL = 2'd0,
    WR_HIGH = 2'd1,
    WR_MEM  = 2'd2,
    WR_NONE = 2'd3
  } wr_mode_e;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regbank_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set wins over clear,
// register 0 is never busy.
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_set,
  input  logic [ADDR_W-1:0]    i_set_addr,
  input  logic                 i_clr,
  input  logic [ADDR_W-1:0]    i_clr_addr,
  output logic [2**ADDR_W-1:0] o_busy_vec
);

  localparam int unsigned NREG = 2**ADDR_W;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  // Next busy vector: apply clear first so a same-address set overrides it
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr) w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_set) w_busy_nxt[i_set_addr] = 1'b1;
    w_busy_nxt[ZERO_REG] = 1'b0;
  end

  // Busy state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign o_busy_vec = r_busy;

endmodule

// File: rtl/regbank_mp.sv
// Two-read / one-write register bank with busy scoreboard and read stall.
// Optional same-cycle write-to-read forwarding under `REGBANK_BYPASS_EN.
module regbank_mp
  import regbank_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    addr_a,
  input  logic [ADDR_W-1:0]    addr_b,
  input  logic                 rd_en,
  output logic [DATA_W-1:0]    data_a,
  output logic [DATA_W-1:0]    data_b,
  output logic                 rd_valid,
  output logic                 rd_stall,
  input  logic                 wr_en,
  input  logic [1:0]           wr_mode,
  input  logic [ADDR_W-1:0]    addr_d,
  input  logic [DATA_W-1:0]    data_d,
  input  logic [DATA_W-1:0]    mem_q,
  input  logic                 busy_set,
  input  logic [ADDR_W-1:0]    busy_addr,
  output logic [2**ADDR_W-1:0] busy_vec
);

  localparam int unsigned NREG = 2**ADDR_W;
  localparam int unsigned HALF = DATA_W / 2;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] r_data_a;
  logic [DATA_W-1:0] r_data_b;
  logic              r_rd_valid;

  wr_mode_e          w_mode;
  logic              w_wr_exec;
  logic [DATA_W-1:0] w_wr_val;
  logic              w_busy_a;
  logic              w_busy_b;
  logic              w_rd_acc;
  logic [DATA_W-1:0] w_rdat_a;
  logic [DATA_W-1:0] w_rdat_b;
  logic [NREG-1:0]   w_busy_vec;

  assign w_mode    = wr_mode_e'(wr_mode);
  assign w_wr_exec = wr_en && (w_mode != WR_NONE) && (addr_d != ZADDR);

  // Post-write value of the destination, merging the kept half for HIGH
  always_comb begin
    w_wr_val = r_regs[addr_d];
    case (w_mode)
      WR_FULL: w_wr_val = data_d;
      WR_HIGH: w_wr_val = {data_d[HALF-1:0], r_regs[addr_d][HALF-1:0]};
      WR_MEM:  w_wr_val = mem_q;
      default: w_wr_val = r_regs[addr_d];
    endcase
  end

  // Effective busy per read port and read data source selection
  always_comb begin
    w_busy_a = w_busy_vec[addr_a] && (addr_a != ZADDR);
    w_busy_b = w_busy_vec[addr_b] && (addr_b != ZADDR);
    w_rdat_a = (addr_a == ZADDR) ? '0 : r_regs[addr_a];
    w_rdat_b = (addr_b == ZADDR) ? '0 : r_regs[addr_b];
`ifdef REGBANK_BYPASS_EN
    if (w_wr_exec && (addr_d == addr_a)) begin
      w_busy_a = 1'b0;
      w_rdat_a = w_wr_val;
    end
    if (w_wr_exec && (addr_d == addr_b)) begin
      w_busy_b = 1'b0;
      w_rdat_b = w_wr_val;
    end
`endif
  end

  assign rd_stall = rd_en && (w_busy_a || w_busy_b);
  assign w_rd_acc = rd_en && !rd_stall;

  regbank_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_set      (busy_set),
    .i_set_addr (busy_addr),
    .i_clr      (w_wr_exec),
    .i_clr_addr (addr_d),
    .o_busy_vec (w_busy_vec)
  );

  // Register file storage; register 0 is never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
    end else if (w_wr_exec) begin
      r_regs[addr_d] <= w_wr_val;
    end
  end

  // Registered read ports: load on accepted read, otherwise hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_a   <= '0;
      r_data_b   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_data_a <= w_rdat_a;
        r_data_b <= w_rdat_b;
      end
    end
  end

  assign data_a   = r_data_a;
  assign data_b   = r_data_b;
  assign rd_valid = r_rd_valid;
  assign busy_vec = w_busy_vec;

endmodule
